// File: rtl/hamming_mem_engine.sv
// SECDED (16,11) Hamming engine: streams two-byte records from IN_BASE to OUT_BASE,
// encoding 11-bit messages or decoding/correcting 16-bit codewords.
module hamming_mem_engine #(
    parameter int  MSG_COUNT = 15,
    parameter int  IN_BASE   = 0,
    parameter int  OUT_BASE  = 30,
    parameter int  ADDR_W    = 8,
    localparam int CNT_W     = $clog2(MSG_COUNT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic              mode,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic [CNT_W-1:0]  corr_count,
    output logic [CNT_W-1:0]  ded_count
);
    localparam int               IDX_W    = (MSG_COUNT > 1) ? $clog2(MSG_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_HI, S_RD_LO, S_WR_HI, S_WR_LO, S_DONE
    } state_t;

    state_t            r_state, w_next;
    logic [IDX_W-1:0]  r_idx;
    logic              r_mode;
    logic [7:0]        r_hi;
    logic [15:0]       r_res;
    logic [CNT_W-1:0]  r_corr, r_ded;

    logic [ADDR_W-1:0] w_in_addr, w_out_addr;
    logic [10:0]       w_msg;
    logic [15:1]       w_cw;
    logic [15:0]       w_enc, w_code, w_fix, w_dec;
    logic [3:0]        w_syn;
    logic              w_par;
    logic [1:0]        w_flags;

    assign w_in_addr  = ADDR_W'(IN_BASE)  + ADDR_W'({r_idx, 1'b0});
    assign w_out_addr = ADDR_W'(OUT_BASE) + ADDR_W'({r_idx, 1'b0});

    // Result is formed in RD_LO from the latched high byte and the live low byte.
    assign w_msg  = {r_hi[2:0], mem_rdata};
    assign w_code = {r_hi, mem_rdata};

    always_comb begin
        w_cw     = '0;
        w_cw[3]  = w_msg[0];
        w_cw[5]  = w_msg[1];
        w_cw[6]  = w_msg[2];
        w_cw[7]  = w_msg[3];
        w_cw[9]  = w_msg[4];
        w_cw[10] = w_msg[5];
        w_cw[11] = w_msg[6];
        w_cw[12] = w_msg[7];
        w_cw[13] = w_msg[8];
        w_cw[14] = w_msg[9];
        w_cw[15] = w_msg[10];
        w_cw[1]  = ^{w_msg[0], w_msg[1], w_msg[3], w_msg[4], w_msg[6], w_msg[8], w_msg[10]};
        w_cw[2]  = ^{w_msg[0], w_msg[2], w_msg[3], w_msg[5], w_msg[6], w_msg[9], w_msg[10]};
        w_cw[4]  = ^{w_msg[1], w_msg[2], w_msg[3], w_msg[7], w_msg[8], w_msg[9], w_msg[10]};
        w_cw[8]  = ^w_msg[10:4];
    end

    assign w_enc = {w_cw, ^w_cw};

    // Syndrome 0 with odd parity means only the overall parity bit c[0] flipped.
    always_comb begin
        w_syn = '0;
        for (int k = 1; k < 16; k++)
            if (w_code[k]) w_syn = w_syn ^ 4'(k);
        w_par   = ^w_code;
        w_fix   = w_code;
        w_flags = 2'b00;
        if (w_par) begin
            w_fix[w_syn] = ~w_code[w_syn];
            w_flags      = 2'b01;
        end else if (w_syn != 4'd0) begin
            w_flags = 2'b10;
        end
    end

    assign w_dec = {w_flags, 3'b000, w_fix[15:13], w_fix[12:9], w_fix[7:5], w_fix[3]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_mode  <= 1'b0;
            r_hi    <= '0;
            r_res   <= '0;
            r_corr  <= '0;
            r_ded   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (req) begin
                        r_idx  <= '0;
                        r_corr <= '0;
                        r_ded  <= '0;
                        r_mode <= mode;
                    end
                end
                S_RD_HI: r_hi <= mem_rdata;
                S_RD_LO: begin
                    r_res <= r_mode ? w_dec : w_enc;
                    if (r_mode && w_flags == 2'b01) r_corr <= r_corr + CNT_W'(1);
                    if (r_mode && w_flags == 2'b10) r_ded  <= r_ded + CNT_W'(1);
                end
                S_WR_LO: if (r_idx != LAST_IDX) r_idx <= r_idx + IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_addr  = '0;
        mem_wr_en = 1'b0;
        mem_wdata = '0;
        case (r_state)
            S_IDLE, S_DONE: if (req) w_next = S_RD_HI;
            S_RD_HI: begin
                mem_addr = w_in_addr;
                w_next   = S_RD_LO;
            end
            S_RD_LO: begin
                mem_addr = w_in_addr + ADDR_W'(1);
                w_next   = S_WR_HI;
            end
            S_WR_HI: begin
                mem_addr  = w_out_addr;
                mem_wr_en = 1'b1;
                mem_wdata = r_res[15:8];
                w_next    = S_WR_LO;
            end
            S_WR_LO: begin
                mem_addr  = w_out_addr + ADDR_W'(1);
                mem_wr_en = 1'b1;
                mem_wdata = r_res[7:0];
                w_next    = (r_idx == LAST_IDX) ? S_DONE : S_RD_HI;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign busy       = (r_state == S_RD_HI) || (r_state == S_RD_LO) ||
                        (r_state == S_WR_HI) || (r_state == S_WR_LO);
    assign done       = (r_state == S_DONE);
    assign corr_count = r_corr;
    assign ded_count  = r_ded;

endmodule

// File: tb/tb_hamming_mem_engine.sv
// Bench for hamming_mem_engine: three instances (default encode, decode 30->60,
// in-place single record) share one byte memory; writes are scoreboarded.
module tb_hamming_mem_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       r_req = 1'b0;
    logic       mode = 1'b0;
    logic       ld = 1'b0;
    int         sel = 0;
    int         total = 0;
    int         bad = 0;

    logic [7:0] mem      [256];
    logic [7:0] init_mem [256];
    logic [7:0] rdata;
    logic [15:0] exp_q [$];
    logic [10:0] msgs [15];

    logic       e_req, d_req, m_req;
    logic       e_done, e_busy, e_wr, d_done, d_busy, d_wr, m_done, m_busy, m_wr;
    logic [7:0] e_addr, e_wdata, d_addr, d_wdata, m_addr, m_wdata;
    logic [3:0] e_corr, e_ded, d_corr, d_ded;
    logic [0:0] m_corr, m_ded;

    logic       s_done, s_busy, s_wr;
    logic [7:0] s_addr, s_wdata;
    logic [3:0] s_corr, s_ded;

    always #5 clk = ~clk;

    assign e_req = r_req && (sel == 0);
    assign d_req = r_req && (sel == 1);
    assign m_req = r_req && (sel == 2);

    hamming_mem_engine u_enc (
        .clk(clk), .reset(reset), .req(e_req), .mode(mode), .done(e_done), .busy(e_busy),
        .mem_addr(e_addr), .mem_wr_en(e_wr), .mem_wdata(e_wdata), .mem_rdata(rdata),
        .corr_count(e_corr), .ded_count(e_ded));

    hamming_mem_engine #(.IN_BASE(30), .OUT_BASE(60)) u_dec (
        .clk(clk), .reset(reset), .req(d_req), .mode(mode), .done(d_done), .busy(d_busy),
        .mem_addr(d_addr), .mem_wr_en(d_wr), .mem_wdata(d_wdata), .mem_rdata(rdata),
        .corr_count(d_corr), .ded_count(d_ded));

    hamming_mem_engine #(.MSG_COUNT(1), .IN_BASE(4), .OUT_BASE(4)) u_min (
        .clk(clk), .reset(reset), .req(m_req), .mode(mode), .done(m_done), .busy(m_busy),
        .mem_addr(m_addr), .mem_wr_en(m_wr), .mem_wdata(m_wdata), .mem_rdata(rdata),
        .corr_count(m_corr), .ded_count(m_ded));

    always_comb begin
        s_done = e_done; s_busy = e_busy; s_wr = e_wr; s_addr = e_addr;
        s_wdata = e_wdata; s_corr = e_corr; s_ded = e_ded;
        case (sel)
            1: begin
                s_done = d_done; s_busy = d_busy; s_wr = d_wr; s_addr = d_addr;
                s_wdata = d_wdata; s_corr = d_corr; s_ded = d_ded;
            end
            2: begin
                s_done = m_done; s_busy = m_busy; s_wr = m_wr; s_addr = m_addr;
                s_wdata = m_wdata; s_corr = 4'(m_corr); s_ded = 4'(m_ded);
            end
            default: ;
        endcase
    end

    assign rdata = mem[s_addr];

    always @(posedge clk) begin
        if (ld) mem <= init_mem;
        else if (s_wr) mem[s_addr] <= s_wdata;
    end

    function automatic logic [15:0] enc_model(input logic [10:0] m);
        logic [15:0] c = '0;
        int pos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        for (int k = 0; k < 11; k++) c[pos[k]] = m[k];
        for (int p = 1; p < 16; p = p * 2) begin
            logic x = 1'b0;
            for (int j = 1; j < 16; j++) if ((j & p) != 0) x = x ^ c[j];
            c[p] = x;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [15:0] dec_model(input logic [15:0] c);
        logic [15:0] f = c;
        logic [10:0] m;
        logic [1:0]  fl;
        int s = 0;
        int pos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
        for (int j = 1; j < 16; j++) if (c[j]) s = s ^ j;
        if (^c) begin
            f[s] = ~f[s];
            fl = 2'b01;
        end else if (s != 0) fl = 2'b10;
        else fl = 2'b00;
        for (int k = 0; k < 11; k++) m[k] = f[pos[k]];
        return {fl, 3'b000, m};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rec(input int base, input int i, input logic [15:0] v);
        exp_q.push_back({8'(base + 2 * i), v[15:8]});
        exp_q.push_back({8'(base + 2 * i + 1), v[7:0]});
    endtask

    task automatic wr_chk();
        logic [15:0] e;
        check("wr_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("wr_addr", s_addr, e[15:8]);
            check("wr_data", s_wdata, e[7:0]);
        end
    endtask

    task automatic load_mem();
        @(negedge clk);
        ld = 1'b1;
        @(posedge clk);
        #1 ld = 1'b0;
    endtask

    task automatic start(input int s, input logic md);
        sel  = s;
        mode = md;
        @(negedge clk);
        r_req = 1'b1;
        @(posedge clk);
        #1;
        r_req = 1'b0;
        mode  = ~md;   // mode must already be latched
        check("busy_on", s_busy, 1);
        check("done_clr", s_done, 0);
    endtask

    task automatic run(input int s, input logic md, input int exp_lat, input int glitch_at);
        int cyc = 0;
        start(s, md);
        while (cyc < 300) begin
            @(negedge clk);
            if (s_wr) wr_chk();
            if (s_done) break;
            if (cyc == glitch_at) r_req = 1'b1;
            @(posedge clk);
            #1 r_req = 1'b0;
            cyc++;
        end
        check("latency", cyc, exp_lat);
        check("busy_off", s_busy, 0);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        logic [15:0] cw;
        int b1, b2;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_done", s_done, 0);
        check("rst_busy", s_busy, 0);
        check("rst_wr", s_wr, 0);
        check("rst_addr", s_addr, 0);
        check("rst_wdata", s_wdata, 0);
        check("rst_corr", s_corr, 0);
        check("rst_ded", s_ded, 0);
        reset = 1'b0;

        // Encode: known vectors plus random messages with junk upper bits
        for (int a = 0; a < 256; a++) init_mem[a] = 8'h00;
        msgs[0] = 11'h555;
        msgs[1] = 11'h000;
        for (int i = 2; i < 15; i++) msgs[i] = 11'($urandom);
        for (int i = 0; i < 15; i++) begin
            init_mem[2 * i]     = {5'($urandom), msgs[i][10:8]};
            init_mem[2 * i + 1] = msgs[i][7:0];
            if (i >= 2) init_mem[2 * i][7:3] = 5'($urandom);
        end
        init_mem[0] = 8'h05;
        init_mem[2] = 8'h00;
        load_mem();
        push_rec(30, 0, 16'hAA5A);
        push_rec(30, 1, 16'h0000);
        for (int i = 2; i < 15; i++) push_rec(30, i, enc_model(msgs[i]));
        run(0, 1'b0, 60, 10);
        check("enc_mem30", mem[30], 8'hAA);
        check("enc_mem31", mem[31], 8'h5A);
        check("enc_corr", s_corr, 0);
        check("enc_ded", s_ded, 0);
        repeat (3) @(negedge clk);
        check("done_hold", s_done, 1);

        // Decode clean codewords produced above
        for (int i = 0; i < 15; i++) push_rec(60, i, {5'b0, msgs[i]});
        run(1, 1'b1, 60, -1);
        check("clean_corr", s_corr, 0);
        check("clean_ded", s_ded, 0);

        // Decode with injected errors; re-armed straight from DONE
        for (int a = 0; a < 256; a++) init_mem[a] = mem[a];
        init_mem[30] = 8'hAA; init_mem[31] = 8'h1A;
        init_mem[32] = 8'hAA; init_mem[33] = 8'h5B;
        init_mem[34] = 8'hA8; init_mem[35] = 8'h1A;
        push_rec(60, 0, 16'h4555);
        push_rec(60, 1, 16'h4555);
        push_rec(60, 2, 16'h8541);
        b1 = $urandom_range(0, 15);
        cw = enc_model(msgs[3]) ^ (16'h1 << b1);
        init_mem[36] = cw[15:8]; init_mem[37] = cw[7:0];
        push_rec(60, 3, dec_model(cw));
        b1 = $urandom_range(0, 15);
        b2 = (b1 + 1 + $urandom_range(0, 14)) % 16;
        cw = enc_model(msgs[4]) ^ (16'h1 << b1) ^ (16'h1 << b2);
        init_mem[38] = cw[15:8]; init_mem[39] = cw[7:0];
        push_rec(60, 4, dec_model(cw));
        for (int i = 5; i < 15; i++) push_rec(60, i, {5'b0, msgs[i]});
        load_mem();
        run(1, 1'b1, 60, 20);
        check("err_corr", s_corr, 3);
        check("err_ded", s_ded, 2);

        // Reset mid-run: records 0-5 land, the rest stays untouched
        for (int a = 0; a < 256; a++) init_mem[a] = mem[a];
        for (int a = 30; a < 60; a++) init_mem[a] = 8'hEE;
        for (int i = 0; i < 15; i++) begin
            msgs[i] = 11'($urandom);
            init_mem[2 * i]     = {5'b0, msgs[i][10:8]};
            init_mem[2 * i + 1] = msgs[i][7:0];
            if (i < 6) push_rec(30, i, enc_model(msgs[i]));
        end
        load_mem();
        start(0, 1'b0);
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            if (s_wr) wr_chk();
            @(posedge clk);
        end
        #2 reset = 1'b1;
        #1;
        check("abort_busy", s_busy, 0);
        check("abort_done", s_done, 0);
        check("abort_wr", s_wr, 0);
        check("abort_queue", exp_q.size(), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 42; a < 60; a++) check("untouched", mem[a], 8'hEE);
        repeat (4) @(negedge clk);
        check("abort_no_done", s_done, 0);

        // In-place, single record
        for (int a = 0; a < 256; a++) init_mem[a] = mem[a];
        init_mem[4] = 8'h05;
        init_mem[5] = 8'h55;
        load_mem();
        push_rec(4, 0, 16'hAA5A);
        run(2, 1'b0, 4, -1);
        check("min_mem4", mem[4], 8'hAA);
        check("min_mem5", mem[5], 8'h5A);
        check("min_done", s_done, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_mem_engine.md
# hamming_mem_engine

Hardware SECDED Hamming engine that walks data memory the way the program_1/program_2 software does, as a drop-in accelerator beside the core on the data-memory port. On a `req` pulse it reads `MSG_COUNT` two-byte records from `IN_BASE`, and either encodes 11-bit messages into 16-bit codewords or decodes/corrects codewords. It writes the results to `OUT_BASE` and raises `done`. Depth, base addresses and mode are generalised beyond the fixed 15-message encode program.

## Interface
- `MSG_COUNT`, default 15: records per run; must be ≥1.
- `IN_BASE`, default 0: byte address of the first input record.
- `OUT_BASE`, default 30: byte address of the first output record.
- `ADDR_W`, default 8: memory address width. Both regions must fit in 2^ADDR_W; this is not checked in hardware.
- `clk`  in  1  clock. One clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  1  start request, sampled on rising `clk`.
- `mode`  in  1  0 = encode, 1 = decode; latched when `req` is accepted.
- `done`  out  1  run complete; held until the next accepted `req` or `reset`.
- `busy`  out  1  run in progress.
- `mem_addr`  out  ADDR_W  byte address.
- `mem_wr_en`  out  1  write strobe; memory writes on rising `clk`.
- `mem_wdata`  out  8  write data.
- `mem_rdata`  in  8  combinational read data for `mem_addr`, valid in the same cycle.
- `corr_count`  out  $clog2(MSG_COUNT+1)  number of records with a corrected single error in the last decode run.
- `ded_count`  out  $clog2(MSG_COUNT+1)  number of records with a detected double error in the last decode run.

## Operation
- **Record layout:** record i occupies base+2i (high byte) and base+2i+1 (low byte).
- **Encode input:** message m[10:0]; high byte = {5'b0, m[10:8]}, low byte = m[7:0]. Upper 5 bits are ignored.
- **Codeword positions:** codeword c[15:0]. Data bits m[0..10] go to positions 3,5,6,7,9,10,11,12,13,14,15 in order.
- **Parity bits:** p1/p2/p4/p8 sit at positions 1/2/4/8. Each is the XOR of all positions whose index has that bit set. c[0] = XOR of c[15:1], giving even overall parity.
- **Decode syndrome:** s = XOR of the indices of all set bits in positions 1..15. P = XOR of all 16 bits.
  - s=0, P=0: clean, flags 00.
  - P=1: single error. Flip bit s (s=0 means c[0] was flipped), flags 01, increment `corr_count`.
  - s≠0, P=0: double error. Data is extracted uncorrected, flags 10, increment `ded_count`.
- **Decode output:** high byte = {flags[1:0], 3'b0, m[10:8]}, low byte = m[7:0].
- **FSM states:** IDLE, RD_HI, RD_LO, WR_HI, WR_LO, DONE.
- **IDLE/DONE:** `req`=1 moves to RD_HI. On acceptance, the record index, `corr_count` and `ded_count` clear to 0, `done` clears, and `mode` is latched.
- **RD_HI:** `mem_addr` = IN_BASE+2i; latch the high byte.
- **RD_LO:** `mem_addr` = IN_BASE+2i+1; latch the low byte; compute the result combinationally from the latched high byte and `mem_rdata`, and register it.
- **WR_HI:** `mem_addr` = OUT_BASE+2i, `mem_wr_en`=1, write the high result byte.
- **WR_LO:** write the low result byte at OUT_BASE+2i+1. If i = MSG_COUNT−1 go to DONE, otherwise increment i and go to RD_HI.
- **Inactive states:** `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0 in IDLE and DONE.
- **`req` while busy:** ignored.
- **Overlapping regions:** the input and output regions may overlap. Each record is read before it is written, so in-place operation (IN_BASE = OUT_BASE) is legal.
- **Counters:** `corr_count` and `ded_count` stay 0 in encode mode and hold their value in DONE.

## Timing
- **Reset values:** `reset` asynchronously forces IDLE. `done`=0, `busy`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wdata`=0, counters 0.
- **Reset mid-run:** the run aborts immediately; bytes already written stay in memory. No `done` is produced.
- **Latency:** `req` sampled at edge E0 → `busy`=1 after E0. The last write happens at edge E0+4·MSG_COUNT; after that edge `busy`=0 and `done`=1. Default: 60 cycles.
- **Throughput:** 4 cycles per record, 2 reads then 2 writes, with no idle gaps.
- **Re-arm from DONE:** `req` in DONE re-arms on the next edge; `done` falls that same edge.

## Test plan
- **Encode, known vector:** MSG_COUNT=15, mode=0, record 0 = 0x05,0x55 → mem[30]=0xAA, mem[31]=0x5A. Record 1 = 0x00,0x00 → 0x00,0x00. `done` rises exactly 60 cycles after the `req` edge.
- **Decode, clean:** encode random messages, then run mode=1 with IN_BASE=30, OUT_BASE=60 → outputs equal the original messages, flags 00, both counters 0.
- **Decode, single error:** record 0xAA,0x1A (bit 6 flipped) → 0x45,0x55, `corr_count`=1. Flipping c[0] (0xAA,0x5B) → 0x45,0x55.
- **Decode, double error:** record 0xA8,0x1A (bits 6 and 9 flipped) → 0x85,0x41, `ded_count`=1.
- **Reset and ignored `req`:** assert `reset` at cycle 25 of a run → `busy`/`done`/`mem_wr_en` go 0 immediately; records 0–5 written, record 6 onward untouched. A `req` pulse while busy has no effect on the cycle count.
- **In-place, minimal depth:** MSG_COUNT=1, IN_BASE=OUT_BASE=4, encode 0x05,0x55 → mem[4]=0xAA, mem[5]=0x5A, `done` after 4 cycles.
